jtframe_cen_lockmon: RTL and testbench



---
 rtl/jtframe_lockmon_pkg.sv | 27 ++
 rtl/jtframe_cen_window.sv | 65 ++++++
 rtl/jtframe_cen_lockmon.sv | 189 ++++++++++++++++++
 tb/tb_jtframe_cen_lockmon.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_lockmon_pkg.sv
// jtframe_lockmon_pkg
// Shared types and helpers for the clock-enable lock monitor.
//   lock_state_t : monitor FSM states (IDLE, ACQ, LOCK, HOLD)
//   in_tol()     : true when |count - expect_v| <= tol, evaluated with a signed
//                  difference wide enough that no operand can overflow it.
package jtframe_lockmon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2,
    HOLD = 2'd3
  } lock_state_t;

  // Window quality test: inclusive tolerance band around the expected count.
  // Operands are zero-extended by two bits so the subtraction stays signed-safe.
  function automatic logic in_tol(input logic [31:0] count,
                                  input logic [31:0] expect_v,
                                  input logic [31:0] tol);
    logic signed [33:0] d;
    logic signed [33:0] t;
    d = $signed({2'b00, count}) - $signed({2'b00, expect_v});
    t = $signed({2'b00, tol});
    return (d >= -t) && (d <= t);
  endfunction

endpackage

// File: rtl/jtframe_cen_window.sv
// jtframe_cen_window
// Measurement window for the lock monitor: a free-running window counter of
// WIN clk cycles and a saturating counter of tick-high cycles inside it.
// Ports:
//   clk   in  : system clock, rising edge
//   rst   in  : synchronous reset, active-high
//   en    in  : window runs while high; low clears both counters
//   tick  in  : strobe under test, one count per high cycle
//   close out : high during the last cycle of a window (win_cnt == WIN-1)
//   count out : window tick count including this cycle's tick; the final
//               count of the window when close is high
module jtframe_cen_window #(
  parameter int WIN = 1024,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tick,
  output logic          close,
  output logic [CW-1:0] count
);

  localparam int WW = $clog2(WIN);
  localparam logic [WW-1:0] LAST    = WW'(WIN - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [WW-1:0] win_cnt_r;
  logic [CW-1:0] tick_cnt_r;
  logic [CW-1:0] cnt_inc_s;
  logic          close_s;

  // Saturating increment and window-close detection.
  always_comb begin
    cnt_inc_s = tick_cnt_r;
    if (tick && (tick_cnt_r != CNT_MAX)) begin
      cnt_inc_s = tick_cnt_r + CW'(1);
    end else begin
      cnt_inc_s = tick_cnt_r;
    end
    close_s = en && (win_cnt_r == LAST);
  end

  // Window and tick counters; a close restarts both at zero so the tick of
  // the first cycle of the new window is counted on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_r  <= {WW{1'b0}};
      tick_cnt_r <= {CW{1'b0}};
    end else if (!en) begin
      win_cnt_r  <= {WW{1'b0}};
      tick_cnt_r <= {CW{1'b0}};
    end else if (close_s) begin
      win_cnt_r  <= {WW{1'b0}};
      tick_cnt_r <= {CW{1'b0}};
    end else begin
      win_cnt_r  <= win_cnt_r + WW'(1);
      tick_cnt_r <= cnt_inc_s;
    end
  end

  assign close = close_s;
  assign count = cnt_inc_s;

endmodule

// File: rtl/jtframe_cen_lockmon.sv
// jtframe_cen_lockmon
// Lock monitor for clock-enable strobes. Counts tick pulses over windows of
// WIN clk cycles, flags each window as fast/slow/good against EXPECT +/- TOL,
// and tracks lock: GOOD consecutive good windows to lock, BAD consecutive bad
// windows to lose it.
// Ports:
//   clk      in  : system clock, rising edge
//   rst      in  : synchronous reset, active-high (priority over en)
//   en       in  : monitor enable; low discards the partial window and idles
//   tick     in  : strobe under test, clk domain
//   meas     out : tick count of the last completed window
//   meas_vld out : one-cycle pulse when meas updates
//   too_fast out : last window count > EXPECT+TOL
//   too_slow out : last window count < EXPECT-TOL
//   locked   out : lock status
module jtframe_cen_lockmon #(
  parameter int WIN    = 1024,
  parameter int CW     = 16,
  parameter int EXPECT = 256,
  parameter int TOL    = 2,
  parameter int GOOD   = 4,
  parameter int BAD    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tick,
  output logic [CW-1:0] meas,
  output logic          meas_vld,
  output logic          too_fast,
  output logic          too_slow,
  output logic          locked
);

  import jtframe_lockmon_pkg::*;

  localparam int GW = $clog2(GOOD + 1);
  localparam int BW = $clog2(BAD + 1);
  localparam logic signed [CW+1:0] EXP_S = (CW+2)'(EXPECT);
  localparam logic signed [CW+1:0] TOL_S = (CW+2)'(TOL);

  logic                 close_s;
  logic [CW-1:0]        count_s;
  logic signed [CW+1:0] diff_s;
  logic                 fast_s;
  logic                 slow_s;
  logic                 good_s;

  lock_state_t   state_r;
  lock_state_t   state_nxt_s;
  logic [GW-1:0] good_cnt_r;
  logic [GW-1:0] good_cnt_nxt_s;
  logic [BW-1:0] bad_cnt_r;
  logic [BW-1:0] bad_cnt_nxt_s;

  logic [CW-1:0] meas_r;
  logic          meas_vld_r;
  logic          too_fast_r;
  logic          too_slow_r;
  logic          locked_r;

  jtframe_cen_window #(
    .WIN (WIN),
    .CW  (CW)
  ) u_window (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .tick  (tick),
    .close (close_s),
    .count (count_s)
  );

  // Classify the closing window. A saturated count still compares correctly
  // because the difference is two bits wider than the count.
  always_comb begin
    diff_s = $signed({2'b00, count_s}) - EXP_S;
    fast_s = (diff_s > TOL_S);
    slow_s = (diff_s < -TOL_S);
    good_s = in_tol(32'(count_s), 32'(EXPECT), 32'(TOL));
  end

  // Lock FSM next-state and good/bad run-length counters.
  always_comb begin
    state_nxt_s    = state_r;
    good_cnt_nxt_s = good_cnt_r;
    bad_cnt_nxt_s  = bad_cnt_r;
    if (!en) begin
      state_nxt_s    = IDLE;
      good_cnt_nxt_s = {GW{1'b0}};
      bad_cnt_nxt_s  = {BW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // First enabled cycle is cycle 0 of a fresh window.
          state_nxt_s    = ACQ;
          good_cnt_nxt_s = {GW{1'b0}};
          bad_cnt_nxt_s  = {BW{1'b0}};
        end
        ACQ: begin
          if (close_s && good_s) begin
            if (good_cnt_r == GW'(GOOD - 1)) begin
              state_nxt_s    = LOCK;
              good_cnt_nxt_s = {GW{1'b0}};
            end else begin
              good_cnt_nxt_s = good_cnt_r + GW'(1);
            end
          end else if (close_s) begin
            good_cnt_nxt_s = {GW{1'b0}};
          end else begin
            good_cnt_nxt_s = good_cnt_r;
          end
        end
        LOCK: begin
          if (close_s && !good_s) begin
            if (BAD == 1) begin
              state_nxt_s    = ACQ;
              good_cnt_nxt_s = {GW{1'b0}};
              bad_cnt_nxt_s  = {BW{1'b0}};
            end else begin
              state_nxt_s   = HOLD;
              bad_cnt_nxt_s = BW'(1);
            end
          end else begin
            state_nxt_s = LOCK;
          end
        end
        HOLD: begin
          if (close_s && good_s) begin
            state_nxt_s   = LOCK;
            bad_cnt_nxt_s = {BW{1'b0}};
          end else if (close_s) begin
            if (bad_cnt_r == BW'(BAD - 1)) begin
              state_nxt_s    = ACQ;
              good_cnt_nxt_s = {GW{1'b0}};
              bad_cnt_nxt_s  = {BW{1'b0}};
            end else begin
              bad_cnt_nxt_s = bad_cnt_r + BW'(1);
            end
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: begin
          state_nxt_s    = IDLE;
          good_cnt_nxt_s = {GW{1'b0}};
          bad_cnt_nxt_s  = {BW{1'b0}};
        end
      endcase
    end
  end

  // State, counters and output registers. locked follows the next state so
  // it changes on the same edge that publishes the closing window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      good_cnt_r <= {GW{1'b0}};
      bad_cnt_r  <= {BW{1'b0}};
      meas_r     <= {CW{1'b0}};
      meas_vld_r <= 1'b0;
      too_fast_r <= 1'b0;
      too_slow_r <= 1'b0;
      locked_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      good_cnt_r <= good_cnt_nxt_s;
      bad_cnt_r  <= bad_cnt_nxt_s;
      locked_r   <= (state_nxt_s == LOCK) || (state_nxt_s == HOLD);
      meas_vld_r <= close_s;
      if (close_s) begin
        meas_r     <= count_s;
        too_fast_r <= fast_s;
        too_slow_r <= slow_s;
      end else begin
        meas_r     <= meas_r;
        too_fast_r <= too_fast_r;
        too_slow_r <= too_slow_r;
      end
    end
  end

  assign meas     = meas_r;
  assign meas_vld = meas_vld_r;
  assign too_fast = too_fast_r;
  assign too_slow = too_slow_r;
  assign locked   = locked_r;

endmodule

// File: tb/tb_jtframe_cen_lockmon.sv
// Testbench for jtframe_cen_lockmon: window-driving tasks push the expected
// window result to a scoreboard queue; a negedge monitor pops it on meas_vld.
module tb_jtframe_cen_lockmon;

  localparam int WIN    = 1024;
  localparam int EXPECT = 256;
  localparam int TOL    = 2;
  localparam int GOOD   = 4;
  localparam int BAD    = 2;

  typedef struct {
    int meas;
    bit tf;
    bit ts;
    bit lk;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        tick;
  logic [15:0] meas;
  logic        meas_vld;
  logic        too_fast;
  logic        too_slow;
  logic        locked;

  // Second instance: 8-bit counter, small EXPECT, so a saturated count is fast.
  logic        rst_sat;
  logic        en_sat;
  logic        tick_sat;
  logic [7:0]  meas_sat;
  logic        meas_vld_sat;
  logic        too_fast_sat;
  logic        too_slow_sat;
  logic        locked_sat;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   gcyc     = 0;
  int   gs       = 0;
  int   bs       = 0;
  bit   m_locked = 1'b0;
  int   last_meas = 0;
  exp_t sb_q[$];

  jtframe_cen_lockmon u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tick     (tick),
    .meas     (meas),
    .meas_vld (meas_vld),
    .too_fast (too_fast),
    .too_slow (too_slow),
    .locked   (locked)
  );

  jtframe_cen_lockmon #(
    .WIN(512), .CW(8), .EXPECT(100), .TOL(2), .GOOD(4), .BAD(2)
  ) u_sat (
    .clk      (clk),
    .rst      (rst_sat),
    .en       (en_sat),
    .tick     (tick_sat),
    .meas     (meas_sat),
    .meas_vld (meas_vld_sat),
    .too_fast (too_fast_sat),
    .too_slow (too_slow_sat),
    .locked   (locked_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every meas_vld pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (meas_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_meas_vld: meas_vld=1 required=0 (meas=%0d)", meas);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_checks += 4;
        if (meas !== e.meas[15:0]) begin
          n_fail++;
          $display("FAIL sb_meas: got %0d required %0d", meas, e.meas);
        end
        if (too_fast !== e.tf) begin
          n_fail++;
          $display("FAIL sb_too_fast: got %0b required %0b (meas %0d)", too_fast, e.tf, e.meas);
        end
        if (too_slow !== e.ts) begin
          n_fail++;
          $display("FAIL sb_too_slow: got %0b required %0b (meas %0d)", too_slow, e.ts, e.meas);
        end
        if (locked !== e.lk) begin
          n_fail++;
          $display("FAIL sb_locked: got %0b required %0b (meas %0d)", locked, e.lk, e.meas);
        end
      end
    end
  end

  function automatic void model_reset();
    gs = 0;
    bs = 0;
    m_locked = 1'b0;
  endfunction

  task automatic step(input bit t);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  // One full window: n ticks spread evenly, or period>0 for a phase-continuous
  // tick every period cycles. Pushes the expected result after the close edge.
  task automatic drive_window(input int n, input int period);
    int   c;
    bit   t;
    exp_t e;
    c = 0;
    for (int i = 0; i < WIN; i++) begin
      if (period > 0) t = ((gcyc % period) == 0);
      else            t = ((((i + 1) * n) / WIN) != ((i * n) / WIN));
      c += int'(t);
      gcyc++;
      step(t);
      if (i == 0) begin
        n_checks++;
        if (sb_q.size() != 0) begin
          n_fail++;
          $display("FAIL sb_backlog: %0d results still pending, required 0", sb_q.size());
        end
      end
    end
    e.meas = c;
    e.tf   = (c > EXPECT + TOL);
    e.ts   = (c < EXPECT - TOL);
    if (e.tf || e.ts) begin bs++; gs = 0; end
    else              begin gs++; bs = 0; end
    if (!m_locked && gs >= GOOD) m_locked = 1'b1;
    else if (m_locked && bs >= BAD) begin m_locked = 1'b0; gs = 0; end
    e.lk = m_locked;
    sb_q.push_back(e);
    last_meas = c;
  endtask

  task automatic restart();
    en = 1'b0;
    step(1'b0);
    model_reset();
    en = 1'b1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b required %0b", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    repeat (3) step(1'b0);
    n_checks += 5;
    if (meas !== 16'd0)     begin n_fail++; $display("FAIL reset_meas: got %0d required 0", meas); end
    if (meas_vld !== 1'b0)  begin n_fail++; $display("FAIL reset_meas_vld: got %0b required 0", meas_vld); end
    if (too_fast !== 1'b0)  begin n_fail++; $display("FAIL reset_too_fast: got %0b required 0", too_fast); end
    if (too_slow !== 1'b0)  begin n_fail++; $display("FAIL reset_too_slow: got %0b required 0", too_slow); end
    if (locked !== 1'b0)    begin n_fail++; $display("FAIL reset_locked: got %0b required 0", locked); end
    rst = 1'b0;
    step(1'b0);
  endtask

  task automatic test_saturation();
    int k;
    rst_sat = 1'b1;
    step(1'b0);
    rst_sat = 1'b0; en_sat = 1'b1; tick_sat = 1'b1;
    for (int w = 0; w < 3; w++) begin
      k = 0;
      while (meas_vld_sat !== 1'b1 && k < 600) begin
        @(posedge clk); #1;
        k++;
      end
      n_checks++;
      if (k >= 600) begin
        n_fail++;
        $display("FAIL sat_timeout: no meas_vld within 600 cycles");
      end else begin
        n_checks += 3;
        if (meas_sat !== 8'd255)     begin n_fail++; $display("FAIL sat_meas: got %0d required 255", meas_sat); end
        if (too_fast_sat !== 1'b1)   begin n_fail++; $display("FAIL sat_too_fast: got %0b required 1", too_fast_sat); end
        if (locked_sat !== 1'b0)     begin n_fail++; $display("FAIL sat_locked: got %0b required 0", locked_sat); end
        @(posedge clk); #1;
      end
    end
    en_sat = 1'b0; tick_sat = 1'b0;
  endtask

  task automatic test_lock_basic();
    model_reset();
    gcyc = 0;
    en = 1'b1;
    for (int w = 0; w < 5; w++) begin
      drive_window(0, 4);
      if (w == 2) check_bit("lock_early", locked, 1'b0);
      if (w == 3) check_bit("lock_at_4th", locked, 1'b1);
    end
  endtask

  task automatic test_too_fast();
    for (int w = 0; w < 2; w++) begin
      drive_window(0, 3);
      check_bit("fast_flag", too_fast, 1'b1);
      if (w == 0) check_bit("hold_keeps_lock", locked, 1'b1);
      else        check_bit("drop_after_2_bad", locked, 1'b0);
    end
  endtask

  task automatic test_boundary();
    restart();
    for (int w = 0; w < 4; w++) drive_window(258, 0);
    check_bit("upper_edge_locks", locked, 1'b1);
    restart();
    for (int w = 0; w < 4; w++) drive_window(259, 0);
    check_bit("over_edge_fast", too_fast, 1'b1);
    check_bit("over_edge_no_lock", locked, 1'b0);
    drive_window(253, 0);
    check_bit("under_edge_slow", too_slow, 1'b1);
    for (int w = 0; w < 4; w++) drive_window(254, 0);
    check_bit("lower_edge_locks", locked, 1'b1);
  endtask

  task automatic test_mixed();
    int pat[7];
    int lk_pat[4];
    pat = '{256, 256, 200, 256, 256, 256, 256};
    lk_pat = '{300, 256, 300, 256};
    restart();
    for (int w = 0; w < 7; w++) begin
      drive_window(pat[w], 0);
      if (w == 5) check_bit("mixed_no_lock_6th", locked, 1'b0);
      if (w == 6) check_bit("mixed_lock_7th", locked, 1'b1);
    end
    for (int w = 0; w < 4; w++) begin
      drive_window(lk_pat[w], 0);
      check_bit("bad_good_keeps_lock", locked, 1'b1);
    end
  endtask

  task automatic test_disrupt();
    for (int i = 0; i < 500; i++) step((i % 4) == 3);
    en = 1'b0;
    step(1'b0);
    check_bit("en_drop_unlocks", locked, 1'b0);
    check_bit("en_drop_no_vld", meas_vld, 1'b0);
    n_checks++;
    if (meas !== last_meas[15:0]) begin
      n_fail++;
      $display("FAIL en_drop_meas_hold: got %0d required %0d", meas, last_meas);
    end
    model_reset();
    en = 1'b1;
    for (int w = 0; w < 4; w++) drive_window(256, 0);
    check_bit("relock", locked, 1'b1);
    for (int i = 0; i < 700; i++) step((i % 4) == 3);
    rst = 1'b1;
    step(1'b1);
    n_checks += 5;
    if (meas !== 16'd0)     begin n_fail++; $display("FAIL rst_mid_meas: got %0d required 0", meas); end
    if (meas_vld !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_meas_vld: got %0b required 0", meas_vld); end
    if (too_fast !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_too_fast: got %0b required 0", too_fast); end
    if (too_slow !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_too_slow: got %0b required 0", too_slow); end
    if (locked !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_locked: got %0b required 0", locked); end
    rst = 1'b0;
    model_reset();
    drive_window(250, 0);
    repeat (3) step(1'b0);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d results pending, required 0", sb_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tick = 1'b0;
    rst_sat = 1'b1; en_sat = 1'b0; tick_sat = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_saturation();
    test_lock_basic();
    test_too_fast();
    test_boundary();
    test_mixed();
    test_disrupt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
